// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice (two half adders + carry FF) per clock.
// Define SERIAL_ADDER_SUB_EN to add an i_sub port for two's-complement subtraction.
module serial_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             i_sub,
`endif
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_sha;
   logic [WIDTH-1:0]   r_shb;
   logic [WIDTH-1:0]   r_res;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_ha1_s;
   logic               w_ha1_c;
   logic               w_ha2_s;
   logic               w_ha2_c;
   logic               w_bit;
   logic               w_carry_next;
   logic               w_last;
   logic [WIDTH-1:0]   w_res_next;
   logic [WIDTH-1:0]   w_b_load;
   logic               w_cin;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_b_load = i_sub ? ~i_b : i_b;
   assign w_cin    = i_sub;
`else
   assign w_b_load = i_b;
   assign w_cin    = 1'b0;
`endif

   // Full-adder slice built from two half-adder stages.
   assign w_ha1_s      = r_sha[0] ^ r_shb[0];
   assign w_ha1_c      = r_sha[0] & r_shb[0];
   assign w_ha2_s      = w_ha1_s ^ r_carry;
   assign w_ha2_c      = w_ha1_s & r_carry;
   assign w_bit        = w_ha2_s;
   assign w_carry_next = w_ha1_c | w_ha2_c;

   // Insert the new bit at the MSB; the concat keeps WIDTH=1 legal.
   assign w_res_next = WIDTH'({w_bit, r_res} >> 1);
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_sha   <= '0;
         r_shb   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_sha   <= i_a;
                  r_shb   <= w_b_load;
                  r_carry <= w_cin;
                  r_cnt   <= '0;
               end
            end
            StRun: begin
               r_sha   <= r_sha >> 1;
               r_shb   <= r_shb >> 1;
               r_carry <= w_carry_next;
               r_res   <= w_res_next;
               r_cnt   <= r_cnt + CNT_W'(1);
               // Visible result only changes once the last bit is in.
               if (w_last) begin
                  r_sum  <= w_res_next;
                  r_cout <= w_carry_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (r_state == StRun);
   assign o_done = (r_state == StDone);
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random operations against an arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         i_rst;
   logic         i_start;
   logic         i_sub;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_sum;
   logic         o_cout;

   int           checks;
   int           failures;
   logic [W-1:0] last_sum;
   logic         last_cout;

   serial_adder #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_start (i_start),
`ifdef SERIAL_ADDER_SUB_EN
      .i_sub   (i_sub),
`endif
      .i_a     (i_a),
      .i_b     (i_b),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_sum   (o_sum),
      .o_cout  (o_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      i_rst   = 1'b1;
      i_start = 1'b1;
      i_a     = W'($urandom);
      i_b     = W'($urandom);
      repeat (3) @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
      checks++; if (o_sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=00", o_sum); end
      checks++; if (o_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", o_cout); end
      i_rst   = 1'b0;
      i_start = 1'b0;
      @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b exp=0", o_busy); end
      last_sum  = '0;
      last_cout = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input string tag);
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      int           busy_cnt;
      bit           seen;
      bit           hold_ok;
      if (sub) begin
         exp_sum  = a - b;
         exp_cout = (a >= b);
      end else begin
         {exp_cout, exp_sum} = {1'b0, a} + {1'b0, b};
      end
      @(negedge clk);
      i_start = 1'b1; i_a = a; i_b = b; i_sub = sub;
      @(negedge clk);
      i_start = 1'b0; i_a = W'($urandom); i_b = W'($urandom); i_sub = 1'($urandom);
      busy_cnt = 0; seen = 0; hold_ok = 1;
      for (int c = 0; c < W + 4; c++) begin
         if (o_done) begin
            seen = 1;
            break;
         end
         if (o_busy) busy_cnt++;
         if (o_sum !== last_sum || o_cout !== last_cout) hold_ok = 0;
         @(negedge clk);
      end
      checks++; if (!seen) begin failures++; $display("FAIL %s done_timeout got=none exp=pulse", tag); end
      checks++; if (busy_cnt != W) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_cnt, W); end
      checks++; if (!hold_ok) begin failures++; $display("FAIL %s sum_hold got=changed exp=%h", tag, last_sum); end
      checks++; if (o_sum !== exp_sum) begin failures++; $display("FAIL %s sum got=%h exp=%h", tag, o_sum, exp_sum); end
      checks++; if (o_cout !== exp_cout) begin failures++; $display("FAIL %s cout got=%b exp=%b", tag, o_cout, exp_cout); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL %s busy_in_done got=%b exp=0", tag, o_busy); end
      @(negedge clk);
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", tag, o_done); end
      last_sum  = exp_sum;
      last_cout = exp_cout;
   endtask

   task automatic test_add_directed();
      run_op(8'd3, 8'd5, 1'b0, "add_3_5");
      run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
      run_op(8'hAA, 8'h55, 1'b0, "add_aa_55");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
         run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
`else
         run_op(W'($urandom), W'($urandom), 1'b0, "random");
`endif
      end
   endtask

   task automatic test_ignore_start();
      int           n_done;
      logic [W-1:0] got_sum;
      logic         got_cout;
      n_done = 0; got_sum = '0; got_cout = 1'b0;
      @(negedge clk);
      i_start = 1'b1; i_a = 8'd10; i_b = 8'd20; i_sub = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      repeat (2) @(negedge clk);
      i_start = 1'b1; i_a = 8'd1; i_b = 8'd1;
      @(negedge clk);
      i_start = 1'b0;
      for (int c = 0; c < W + 4; c++) begin
         if (o_done) begin
            n_done++;
            got_sum  = o_sum;
            got_cout = o_cout;
         end
         @(negedge clk);
      end
      checks++; if (n_done != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
      checks++; if (got_sum !== 8'd30) begin failures++; $display("FAIL ignore_sum got=%h exp=1e", got_sum); end
      checks++; if (got_cout !== 1'b0) begin failures++; $display("FAIL ignore_cout got=%b exp=0", got_cout); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL ignore_idle got=%b exp=0", o_busy); end
      last_sum  = 8'd30;
      last_cout = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit activity;
      @(negedge clk);
      i_start = 1'b1; i_a = 8'd100; i_b = 8'd100; i_sub = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", o_done); end
      checks++; if (o_sum !== '0) begin failures++; $display("FAIL midrst_sum got=%h exp=00", o_sum); end
      checks++; if (o_cout !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b exp=0", o_cout); end
      activity = 0;
      for (int c = 0; c < W + 4; c++) begin
         if (o_done || o_busy) activity = 1;
         @(negedge clk);
      end
      checks++; if (activity) begin failures++; $display("FAIL midrst_no_done got=activity exp=quiet"); end
      last_sum  = '0;
      last_cout = 1'b0;
      run_op(8'd7, 8'd9, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back();
      int  done_at[$];
      bit  sum_ok;
      bit  busy_after_done;
      bit  prev_done;
      bit  settled;
      sum_ok = 1; busy_after_done = 0; prev_done = 0;
      @(negedge clk);
      i_start = 1'b1; i_a = 8'd1; i_b = 8'd2; i_sub = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (prev_done && o_busy) busy_after_done = 1;
         prev_done = o_done;
         if (o_done) begin
            done_at.push_back(i);
            if (o_sum !== 8'd3 || o_cout !== 1'b0) sum_ok = 0;
         end
      end
      i_start = 1'b0;
      checks++; if (done_at.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", done_at.size()); end
      for (int k = 1; k < done_at.size(); k++) begin
         checks++;
         if (done_at[k] - done_at[k-1] != W + 2) begin
            failures++;
            $display("FAIL b2b_period got=%0d exp=%0d", done_at[k] - done_at[k-1], W + 2);
         end
      end
      checks++; if (!sum_ok) begin failures++; $display("FAIL b2b_sum got=wrong exp=03"); end
      checks++; if (busy_after_done) begin failures++; $display("FAIL b2b_start_in_done got=accepted exp=ignored"); end
      settled = 0;
      for (int c = 0; c < W + 4 && !settled; c++) begin
         @(negedge clk);
         if (!o_busy && !o_done) settled = 1;
      end
      checks++; if (!settled) begin failures++; $display("FAIL b2b_drain got=busy exp=idle"); end
      last_sum  = 8'd3;
      last_cout = 1'b0;
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      run_op(8'd5, 8'd7, 1'b1, "sub_5_7");
      run_op(8'd9, 8'd4, 1'b1, "sub_9_4");
      run_op(8'd0, 8'd0, 1'b1, "sub_0_0");
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      last_sum  = '0;
      last_cout = 1'b0;
      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_sub     = 1'b0;
      i_a       = '0;
      i_b       = '0;
      test_reset();
      test_add_directed();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
